// File: rtl/piano_score_player_if.sv
// Score ROM read port: the player drives address and read strobe.
// The ROM returns the event word on the cycle after the strobe.
interface piano_score_player_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned EVT_WIDTH  = 11
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_rd_en;
    logic [EVT_WIDTH-1:0]  rom_data;

    modport master (output rom_addr, output rom_rd_en, input rom_data);
    modport slave  (input rom_addr, input rom_rd_en, output rom_data);
endinterface

// File: rtl/piano_score_player.sv
// Score player: fetches {octave, key, duration} events from a ROM and holds
// each key for duration*TICK_CYCLES clocks; a zero duration ends the score.
module piano_score_player #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TICK_MS     = 20,
    parameter int unsigned KEY_ID_BITS = 3,
    parameter int unsigned OCTAVE_BITS = 2,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DUR_BITS    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   play_start_pulse,
    input  logic                   play_stop_pulse,
    piano_score_player_if.master   rom,
    output logic [KEY_ID_BITS-1:0] playback_key_id,
    output logic                   playback_key_is_pressed,
    output logic                   playback_octave_up,
    output logic                   playback_octave_down,
    output logic                   is_playing,
    output logic                   done_pulse
);
    localparam int unsigned TICK_CYCLES = TICK_MS * (CLK_FREQ_HZ / 1000);
    localparam int unsigned EVT_WIDTH   = OCTAVE_BITS + KEY_ID_BITS + DUR_BITS;
    localparam int unsigned TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {IDLE, FETCH, LATCH, HOLD} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [TICK_W-1:0]       tick_q;
    logic [DUR_BITS-1:0]     dur_q;
    logic [EVT_WIDTH-1:0]    evt;
    logic [DUR_BITS-1:0]     evt_dur;
    logic [KEY_ID_BITS-1:0]  evt_key;
    logic [OCTAVE_BITS-1:0]  evt_oct;
    logic                    addr_start, addr_inc, load_evt, clear_out, done_next;
    logic                    hold_expire;

    assign evt     = rom.rom_data;
    assign evt_dur = evt[DUR_BITS-1:0];
    assign evt_key = evt[DUR_BITS +: KEY_ID_BITS];
    assign evt_oct = evt[DUR_BITS + KEY_ID_BITS +: OCTAVE_BITS];

    assign rom.rom_addr  = addr_q;
    assign rom.rom_rd_en = (state == FETCH);
    assign is_playing    = (state != IDLE);
    assign hold_expire   = (tick_q == TICK_LAST) && (dur_q == DUR_BITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_start = 1'b0;
        addr_inc   = 1'b0;
        load_evt   = 1'b0;
        clear_out  = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (play_start_pulse && !play_stop_pulse) begin
                    state_next = FETCH;
                    addr_start = 1'b1;
                end
            end
            FETCH: begin
                if (play_stop_pulse) begin
                    state_next = IDLE;
                    clear_out  = 1'b1;
                end else begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (play_stop_pulse) begin
                    state_next = IDLE;
                    clear_out  = 1'b1;
                end else if (evt_dur == '0) begin
                    state_next = IDLE;
                    clear_out  = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    state_next = HOLD;
                    load_evt   = 1'b1;
                end
            end
            HOLD: begin
                if (play_stop_pulse) begin
                    state_next = IDLE;
                    clear_out  = 1'b1;
                end else if (hold_expire) begin
                    // The last ROM word ends the score rather than wrapping to 0.
                    if (addr_q == ADDR_LAST) begin
                        state_next = IDLE;
                        clear_out  = 1'b1;
                        done_next  = 1'b1;
                    end else begin
                        state_next = FETCH;
                        addr_inc   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                clear_out  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q                  <= '0;
            tick_q                  <= '0;
            dur_q                   <= '0;
            playback_key_id         <= '0;
            playback_key_is_pressed <= 1'b0;
            playback_octave_up      <= 1'b0;
            playback_octave_down    <= 1'b0;
            done_pulse              <= 1'b0;
        end else begin
            done_pulse <= done_next;

            if (addr_start) begin
                addr_q <= '0;
            end else if (addr_inc) begin
                addr_q <= addr_q + 1'b1;
            end

            if (clear_out) begin
                playback_key_id         <= '0;
                playback_key_is_pressed <= 1'b0;
                playback_octave_up      <= 1'b0;
                playback_octave_down    <= 1'b0;
            end else if (load_evt) begin
                playback_key_id         <= evt_key;
                playback_key_is_pressed <= (evt_key != '0);
                playback_octave_up      <= (evt_oct == OCTAVE_BITS'(1));
                playback_octave_down    <= (evt_oct == OCTAVE_BITS'(2));
            end

            if (clear_out) begin
                tick_q <= '0;
                dur_q  <= '0;
            end else if (load_evt) begin
                tick_q <= '0;
                dur_q  <= evt_dur;
            end else if (state == HOLD) begin
                if (tick_q == TICK_LAST) begin
                    tick_q <= '0;
                    dur_q  <= dur_q - 1'b1;
                end else begin
                    tick_q <= tick_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/piano_score_player.md
PIANO_SCORE_PLAYER -- requirements
Module: piano_score_player

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter TICK_MS, default 20, duration tick length; TICK_CYCLES = TICK_MS*(CLK_FREQ_HZ/1000).
REQ-003 SHALL have parameter KEY_ID_BITS, default 3, key ID width (0 = rest).
REQ-004 SHALL have parameter OCTAVE_BITS, default 2, octave code width.
REQ-005 SHALL have parameter ADDR_WIDTH, default 8, score ROM address width.
REQ-006 SHALL have parameter DUR_BITS, default 6, event duration width in ticks; EVT_WIDTH = OCTAVE_BITS+KEY_ID_BITS+DUR_BITS.
REQ-007 SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-008 play_start_pulse  input  1  single-cycle start request.
REQ-009 play_stop_pulse  input  1  single-cycle abort request.
REQ-010 rom_addr  output  ADDR_WIDTH  score ROM read address.
REQ-011 rom_rd_en  output  1  score ROM read strobe.
REQ-012 rom_data  input  EVT_WIDTH  event word {octave_code, key_id, duration}, valid the cycle after rom_rd_en.
REQ-013 playback_key_id  output  KEY_ID_BITS  current key ID.
REQ-014 playback_key_is_pressed  output  1  high when current key_id != 0.
REQ-015 playback_octave_up / playback_octave_down  output  1 each  decoded octave flags.
REQ-016 is_playing  output  1  high in every non-IDLE state.
REQ-017 done_pulse  output  1  one-cycle pulse on natural score end.

Function
REQ-018 SHALL implement states IDLE, FETCH, LATCH, HOLD.
REQ-019 IDLE: play_start_pulse=1 and play_stop_pulse=0 SHALL set rom_addr=0 and enter FETCH next cycle; otherwise remain IDLE.
REQ-020 rom_rd_en SHALL be high exactly during FETCH; FETCH SHALL last one cycle then enter LATCH.
REQ-021 LATCH SHALL capture rom_data; duration==0 is end-of-score: clear all playback outputs, pulse done_pulse one cycle, enter IDLE.
REQ-022 LATCH with duration!=0: register key_id, pressed=(key_id!=0), octave code 01->up=1, 10->down=1, 00 and 11->both 0; load duration counter, clear tick timer, enter HOLD; outputs visible the cycle after LATCH.
REQ-023 HOLD: tick timer counts 0..TICK_CYCLES-1; at TICK_CYCLES-1 it wraps and the duration counter decrements; HOLD SHALL last exactly duration*TICK_CYCLES cycles.
REQ-024 HOLD expiry: if rom_addr == 2^ADDR_WIDTH-1, SHALL behave as end-of-score (REQ-021, no wrap); else rom_addr+1 and enter FETCH.
REQ-025 Playback outputs SHALL hold previous event values through FETCH/LATCH; each event therefore spans duration*TICK_CYCLES+2 cycles, with no gap between events.
REQ-026 play_stop_pulse in any non-IDLE state SHALL enter IDLE next cycle, clear playback outputs, no done_pulse.
REQ-027 play_start_pulse while non-IDLE SHALL be ignored; start and stop in the same IDLE cycle: stop wins.
REQ-028 rom_addr SHALL change only on start (to 0) and on HOLD expiry (+1); held otherwise.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, rom_addr=0, rom_rd_en=0, all playback outputs 0, is_playing=0, done_pulse=0, counters 0, including mid-playback.

Verification (CLK_FREQ_HZ=4000, TICK_MS=1 -> TICK_CYCLES=4)
REQ-030 ROM[0]={01,3'd5,6'd2}, ROM[1]=dur 0; start at T -> rd_en at T+1 addr 0; key_id=5, pressed=1, up=1 from T+3 for 10 cycles; done_pulse one cycle; outputs 0.
REQ-031 ROM[0]={00,3'd0,6'd3} rest -> pressed=0, key_id=0 for 14 cycles, then next event fetched at addr 1.
REQ-032 Octave codes 10 and 11 -> down=1/up=0 and up=0/down=0 respectively.
REQ-033 Stop pulse mid-HOLD -> IDLE next cycle, outputs 0, is_playing=0, done_pulse stays 0; start during HOLD ignored.
REQ-034 ADDR_WIDTH=2, all four words dur=1 -> plays addr 0..3, then done_pulse, rom_addr never wraps to 0 before done.
REQ-035 rst_n low during HOLD -> all outputs 0 immediately, no done_pulse; fresh start replays from addr 0.
